// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] IF_NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_BOOT  = 2'd0,
    S_FETCH = 2'd1,
    S_HOLD  = 2'd2,
    S_FAULT = 2'd3
  } fetch_state_e;

  // Force a byte address onto a word boundary.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/if_pc_gen.sv
// Next-fetch-address selection: redirect, pending squash target, pc+4 or hold.
module if_pc_gen
  import if_fetch_pkg::*;
(
  input  fetch_state_e    i_state,
  input  logic            i_redirect,
  input  logic [XLEN-1:0] i_redirect_pc,
  input  logic            i_squash,
  input  logic [XLEN-1:0] i_pending,
  input  logic            i_imem_ready,
  input  logic            i_stall,
  input  logic [XLEN-1:0] i_fetch_addr,
  input  logic [XLEN-1:0] i_pc_4,
  output logic [XLEN-1:0] o_target,
  output logic [XLEN-1:0] o_next_addr
);

  logic [XLEN-1:0] w_target;

  assign w_target = align_word(i_redirect_pc);
  assign o_target = w_target;

  // An in-flight request keeps its address until imem_ready retires it.
  always_comb begin
    o_next_addr = i_fetch_addr;
    if (i_state == S_FETCH) begin
      if (i_imem_ready) begin
        if (i_redirect) begin
          o_next_addr = w_target;
        end else if (i_squash) begin
          o_next_addr = i_pending;
        end
      end
    end else if (i_redirect) begin
      o_next_addr = w_target;
    end else if ((i_state == S_HOLD) && !i_stall) begin
      o_next_addr = i_pc_4;
    end
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch front end: owns the PC, issues single-outstanding imem
// requests and presents pc/pc_4/instruction to IF/ID. Optional macro:
// IF_FETCH_MISALIGN_EN adds misaligned-redirect fault reporting.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [XLEN-1:0] NOP_INST = IF_NOP_INST
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  output logic [XLEN-1:0] pc,
  output logic [XLEN-1:0] pc_4,
  output logic [XLEN-1:0] instruction,
`ifdef IF_FETCH_MISALIGN_EN
  output logic            fetch_misalign,
`endif
  output logic            busy
);

  fetch_state_e    r_state;
  logic [XLEN-1:0] r_fetch_addr;
  logic [XLEN-1:0] r_pending;
  logic            r_squash;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_pc_4;
  logic [XLEN-1:0] r_inst;

  logic [XLEN-1:0] w_target;
  logic [XLEN-1:0] w_next_addr;

  if_pc_gen u_pc_gen (
    .i_state       (r_state),
    .i_redirect    (redirect),
    .i_redirect_pc (redirect_pc),
    .i_squash      (r_squash),
    .i_pending     (r_pending),
    .i_imem_ready  (imem_ready),
    .i_stall       (stall),
    .i_fetch_addr  (r_fetch_addr),
    .i_pc_4        (r_pc_4),
    .o_target      (w_target),
    .o_next_addr   (w_next_addr)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= S_BOOT;
      r_fetch_addr <= RESET_PC;
      r_pending    <= '0;
      r_squash     <= 1'b0;
      r_pc         <= '0;
      r_pc_4       <= '0;
      r_inst       <= NOP_INST;
    end else begin
      r_fetch_addr <= w_next_addr;
`ifdef IF_FETCH_MISALIGN_EN
      if (redirect && (redirect_pc[1:0] != 2'b00)) begin
        r_state  <= S_FAULT;
        r_squash <= 1'b0;
        r_inst   <= NOP_INST;
      end else
`endif
      begin
        case (r_state)
          S_BOOT: begin
            r_state <= S_FETCH;
          end
          S_FETCH: begin
            if (imem_ready) begin
              if (redirect || r_squash) begin
                // Stale word: drop it and restart at the new target.
                r_squash <= 1'b0;
              end else begin
                r_pc    <= r_fetch_addr;
                r_pc_4  <= r_fetch_addr + XLEN'(4);
                r_inst  <= imem_rdata;
                r_state <= S_HOLD;
              end
            end else if (redirect) begin
              r_squash  <= 1'b1;
              r_pending <= w_target;
            end
          end
          S_HOLD: begin
            if (redirect || !stall) begin
              r_inst  <= NOP_INST;
              r_state <= S_FETCH;
            end
          end
`ifdef IF_FETCH_MISALIGN_EN
          S_FAULT: begin
            if (redirect) begin
              r_state <= S_FETCH;
            end
          end
`endif
          default: begin
            r_state <= S_FETCH;
          end
        endcase
      end
    end
  end

  assign imem_req    = (r_state == S_FETCH);
  assign imem_addr   = r_fetch_addr;
  assign pc          = r_pc;
  assign pc_4        = r_pc_4;
  assign instruction = r_inst;

  // busy gates the IF/ID register in the same cycle, so it follows stall/redirect directly.
  assign busy = (r_state != S_HOLD) | stall | redirect;

`ifdef IF_FETCH_MISALIGN_EN
  assign fetch_misalign = (r_state == S_FAULT);
`endif

endmodule
